mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage of the pipelined CPU. It computes a full double-width product, or a quotient and remainder, over N+2 cycles. The low half or quotient is returned on `result`; the high half or remainder is returned on `r0`, which feeds the R0 write path. The hazard unit holds the IF/ID and ID/EX buffers while `busy` is high and flushes the unit on branch mispredict.

---
 rtl/mul_div_unit_pkg.sv | 31 +++
 rtl/mul_div_unit_twos_negate.sv | 19 +
 rtl/mul_div_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared encodings and helpers for the iterative multiply/divide unit
//
// Purpose : operation codes, FSM state codes and the default operand width
//           shared by mul_div_unit, its sub-module and anything that drives it.
// Contents: MD_DEFAULT_WIDTH, MD_SMUL/MD_SDIV/MD_UMUL/MD_UDIV,
//           ST_IDLE/ST_CALC/ST_FIX/ST_DONE, op decode helpers.

package mul_div_unit_pkg;

    localparam int MD_DEFAULT_WIDTH = 16;

    // op[0] selects divide, op[1] selects unsigned.
    localparam logic [1:0] MD_SMUL = 2'b00;
    localparam logic [1:0] MD_SDIV = 2'b01;
    localparam logic [1:0] MD_UMUL = 2'b10;
    localparam logic [1:0] MD_UDIV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[1];
    endfunction

endpackage

// File: rtl/mul_div_unit_twos_negate.sv
// rtl/mul_div_unit_twos_negate.sv - conditional two's-complement negate
//
// Purpose : result = negate ? -value : value (modulo 2^N). Used for operand
//           magnitudes on entry and for the sign correction of results.
// Ports   : value  in  N  operand
//           negate in  1  1 = negate, 0 = pass through
//           result out N  conditionally negated operand

module twos_negate #(
    parameter int N = 16
) (
    input  logic [N-1:0] value,
    input  logic         negate,
    output logic [N-1:0] result
);

    assign result = negate ? (~value + N'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative signed/unsigned multiply and divide, N+2 cycle latency
//
// Purpose : radix-2 shift-add multiply (2N-bit product) and restoring divide
//           (quotient + remainder) for the execute stage.
// Ports   : clock        in  1  rising-edge clock
//           reset        in  1  asynchronous active-low reset
//           start        in  1  request, sampled only in IDLE or DONE
//           op           in  2  00 smul, 01 sdiv, 10 umul, 11 udiv
//           in1          in  N  multiplicand / dividend
//           in2          in  N  multiplier / divisor
//           flush        in  1  synchronous cancel, wins over start
//           busy         out 1  high in CALC and FIX
//           done         out 1  one-cycle pulse, results valid
//           result       out N  product low half / quotient
//           r0           out N  product high half / remainder
//           overflow     out 1  valid with done
//           div_by_zero  out 1  valid with done

module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int N = MD_DEFAULT_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [N-1:0] r0,
    output logic         overflow,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    logic [1:0]     state;
    logic [CW-1:0]  count;
    logic [1:0]     op_q;
    logic           neg_lo;       // negate product / quotient in FIX
    logic           neg_hi;       // negate remainder in FIX (dividend sign)
    // Multiply: {high, low}, low starts as the multiplier and is shifted out.
    // Divide  : {partial remainder, quotient}, quotient starts as the dividend.
    logic [2*N-1:0] acc;
    logic [N-1:0]   operand_b;    // multiplicand or divisor magnitude

    // ------------------------------------------------------------------
    // Entry: operand magnitudes and signs
    // ------------------------------------------------------------------
    logic           in_signed;
    logic           in_div;
    logic [N-1:0]   mag1;
    logic [N-1:0]   mag2;
    logic           in_div_zero;
    logic           idle_or_done;

    assign in_signed    = op_is_signed(op);
    assign in_div       = op_is_div(op);
    assign in_div_zero  = in_div && (in2 == '0);
    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);

    // 0x8..0 negates to itself, which is the correct unsigned magnitude.
    twos_negate #(.N(N)) u_abs1 (
        .value  (in1),
        .negate (in_signed & in1[N-1]),
        .result (mag1)
    );

    twos_negate #(.N(N)) u_abs2 (
        .value  (in2),
        .negate (in_signed & in2[N-1]),
        .result (mag2)
    );

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;
    logic [N:0]     div_shift;
    logic           div_ge;
    logic [N-1:0]   div_diff;
    logic [2*N-1:0] div_next;
    logic [2*N-1:0] acc_next;

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the carry in from the top.
    assign mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, operand_b} : '0);
    assign mul_next = {mul_sum, acc[N-1:1]};

    // Restoring divide: bring the next dividend bit into the remainder; the
    // extra top bit of div_shift is the guard bit. The partial remainder
    // stays below the divisor, so the difference always fits in N bits.
    assign div_shift = {acc[2*N-1:N], acc[N-1]};
    assign div_ge    = div_shift >= {1'b0, operand_b};
    assign div_diff  = div_shift[N-1:0] - operand_b;
    assign div_next  = div_ge ? {div_diff, acc[N-2:0], 1'b1}
                              : {div_shift[N-1:0], acc[N-2:0], 1'b0};

    assign acc_next = op_is_div(op_q) ? div_next : mul_next;

    // ------------------------------------------------------------------
    // Sign correction
    // ------------------------------------------------------------------
    logic [2*N-1:0] acc_fixed;
    logic [N-1:0]   rem_fixed;
    logic [N-1:0]   fix_lo;
    logic [N-1:0]   fix_hi;
    logic           fix_ovf;

    // For divide only the low half of acc_fixed is used; the low N bits of a
    // 2N-bit negation equal the N-bit negation of the quotient.
    twos_negate #(.N(2*N)) u_fix_prod (
        .value  (acc),
        .negate (neg_lo),
        .result (acc_fixed)
    );

    twos_negate #(.N(N)) u_fix_rem (
        .value  (acc[2*N-1:N]),
        .negate (neg_hi),
        .result (rem_fixed)
    );

    assign fix_lo = acc_fixed[N-1:0];
    assign fix_hi = op_is_div(op_q) ? rem_fixed : acc_fixed[2*N-1:N];

    always_comb begin
        fix_ovf = 1'b0;
        case (op_q)
            MD_SMUL: fix_ovf = (fix_hi != {N{fix_lo[N-1]}});
            MD_UMUL: fix_ovf = (fix_hi != '0);
            // Only 0x8..0 / -1 yields a positive quotient with the MSB set.
            MD_SDIV: fix_ovf = !neg_lo && acc[N-1];
            default: fix_ovf = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            op_q        <= MD_SMUL;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            acc         <= '0;
            operand_b   <= '0;
            result      <= '0;
            r0          <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            // Cancel without touching the visible results.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_CALC: begin
                    acc <= acc_next;
                    if (count == '0) begin
                        state <= ST_FIX;
                    end else begin
                        count <= count - CW'(1);
                    end
                end

                ST_FIX: begin
                    result      <= fix_lo;
                    r0          <= fix_hi;
                    overflow    <= fix_ovf;
                    div_by_zero <= 1'b0;
                    state       <= ST_DONE;
                end

                default: begin
                    if (idle_or_done && start) begin
                        op_q <= op;
                        if (in_div_zero) begin
                            // Bypass: results are known without iterating.
                            result      <= '1;
                            r0          <= in1;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            acc       <= {{N{1'b0}}, (in_div ? mag1 : mag2)};
                            operand_b <= in_div ? mag2 : mag1;
                            neg_lo    <= in_signed & (in1[N-1] ^ in2[N-1]);
                            neg_hi    <= in_signed & (in_div ? in1[N-1]
                                                             : (in1[N-1] ^ in2[N-1]));
                            count     <= CW'(N - 1);
                            state     <= ST_CALC;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Decoded straight from the state register, so independent of start.
    assign busy = (state == ST_CALC) || (state == ST_FIX);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit (N=16)

module tb_mul_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] r0;
    logic        overflow;
    logic        div_by_zero;

    int vectors;
    int miscompares;
    int edges;
    int busy_cyc;
    int seen_done;

    mul_div_unit #(.N(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .r0          (r0),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request and waits (bounded) for done; edges counts clock
    // edges from the accepting edge up to and including the done edge.
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          output int n_edges, output int n_busy);
        op = o; in1 = a; in2 = b; start = 1'b1;
        n_edges = 0; n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            n_edges++;
            if (busy) n_busy++;
            if (done) break;
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0; flush = 1'b0;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_r0", r0, 0);
        check("rst_flags", {overflow, div_by_zero}, 0);
        reset = 1'b1;
        step();

        // Unsigned mul 0xFFFF * 0xFFFF = 0xFFFE_0001
        run_op(2'b10, 16'hFFFF, 16'hFFFF, edges, busy_cyc);
        check("umul_edges", edges, 18);
        check("umul_busy_cycles", busy_cyc, 17);
        check("umul_result", result, 16'h0001);
        check("umul_r0", r0, 16'hFFFE);
        check("umul_ovf", overflow, 1);
        check("umul_dbz", div_by_zero, 0);
        step();
        check("umul_done_pulse", done, 0);

        // Signed mul -3 * 7 = -21
        run_op(2'b00, 16'hFFFD, 16'h0007, edges, busy_cyc);
        check("smul_edges", edges, 18);
        check("smul_result", result, 16'hFFEB);
        check("smul_r0", r0, 16'hFFFF);
        check("smul_ovf", overflow, 0);
        // Back-to-back: start presented in the DONE cycle
        run_op(2'b00, 16'h0002, 16'h0003, edges, busy_cyc);
        check("b2b_edges", edges, 18);
        check("b2b_result", result, 16'h0006);
        check("b2b_r0", r0, 16'h0000);

        // Signed mul overflow: 0x100 * 0x100 = 0x1_0000
        run_op(2'b00, 16'h0100, 16'h0100, edges, busy_cyc);
        check("smul_ovf_result", result, 16'h0000);
        check("smul_ovf_r0", r0, 16'h0001);
        check("smul_ovf_flag", overflow, 1);

        // Unsigned div by zero: bypass
        step();
        run_op(2'b11, 16'h1234, 16'h0000, edges, busy_cyc);
        check("dbz_edges", edges, 1);
        check("dbz_busy", busy_cyc, 0);
        check("dbz_result", result, 16'hFFFF);
        check("dbz_r0", r0, 16'h1234);
        check("dbz_flag", div_by_zero, 1);
        check("dbz_ovf", overflow, 0);

        // Signed div -7 / 2 = -3 rem -1
        step();
        run_op(2'b01, 16'hFFF9, 16'h0002, edges, busy_cyc);
        check("sdiv_edges", edges, 18);
        check("sdiv_result", result, 16'hFFFD);
        check("sdiv_r0", r0, 16'hFFFF);
        check("sdiv_flags", {overflow, div_by_zero}, 0);

        // Unsigned div 0xFFFF / 0x10 = 0x0FFF rem 0xF
        step();
        run_op(2'b11, 16'hFFFF, 16'h0010, edges, busy_cyc);
        check("udiv_result", result, 16'h0FFF);
        check("udiv_r0", r0, 16'h000F);
        check("udiv_ovf", overflow, 0);

        // Signed div 0x8000 / -1 overflows
        step();
        run_op(2'b01, 16'h8000, 16'hFFFF, edges, busy_cyc);
        check("sdiv_ovf_result", result, 16'h8000);
        check("sdiv_ovf_r0", r0, 16'h0000);
        check("sdiv_ovf_flag", overflow, 1);

        // Flush in the 5th CALC cycle
        step();
        op = 2'b10; in1 = 16'h0003; in2 = 16'h0005; start = 1'b1;
        step();
        start = 1'b0;
        check("flush_pre_busy", busy, 1);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        check("flush_keep_result", result, 16'h8000);
        check("flush_keep_ovf", overflow, 1);
        seen_done = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (done) seen_done++;
        end
        check("flush_no_done", seen_done, 0);

        // flush together with start: stays IDLE
        op = 2'b10; in1 = 16'h0003; in2 = 16'h0005; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", busy, 0);
        step();
        check("flush_start_idle", {busy, done}, 0);

        // Asynchronous reset mid-CALC, away from the clock edge
        op = 2'b10; in1 = 16'h0003; in2 = 16'h0005; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #3 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_r0", r0, 0);
        check("arst_flags", {overflow, div_by_zero}, 0);
        #2 reset = 1'b1;

        // Normal op after release: 0x00FF * 0x0101 = 0xFFFF
        run_op(2'b10, 16'h00FF, 16'h0101, edges, busy_cyc);
        check("post_rst_edges", edges, 18);
        check("post_rst_result", result, 16'hFFFF);
        check("post_rst_r0", r0, 16'h0000);
        check("post_rst_ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
